delta_sum_decoder: RTL and testbench

- Inverse of the team's registered a-minus-b subtractor pipeline.
- Accepts a stream of signed differences (delta = new sample - previous sample), accumulates them onto a seeded base value and emits reconstructed unsigned samples.
- Sits downstream of difference-encoding datapaths and rebuilds the original 4-bit sample stream through a 3-stage valid/ready pipeline.

---
 rtl/delta_sum_decoder_if.sv | 24 ++
 rtl/delta_sum_decoder.sv | 141 ++++++++++++++
 tb/tb_delta_sum_decoder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/delta_sum_decoder_if.sv
// Handshake bundle for delta_sum_decoder: the delta input stream and
// the reconstructed-sample output stream.
interface delta_sum_decoder_if #(
    parameter int DW = 4
);
    logic [DW:0]   dIn;
    logic          dValid;
    logic          dReady;
    logic [DW-1:0] sOut;
    logic          sValid;
    logic          sReady;

    // Environment side: produces deltas, consumes samples
    modport master (
        output dIn, dValid, sReady,
        input  dReady, sOut, sValid
    );

    // Decoder side: consumes deltas, produces samples
    modport slave (
        input  dIn, dValid, sReady,
        output dReady, sOut, sValid
    );
endinterface

// File: rtl/delta_sum_decoder.sv
// Delta-sum decoder: accumulates signed deltas onto a seeded base and
// emits saturated unsigned samples through a 3-stage valid/ready pipeline.
//   S1: delta register
//   S2: accumulate (acc updated here), result held in s2_data_q
//   S3: output register driving sOut/sValid
module delta_sum_decoder #(
    parameter int DW = 4,
    parameter int CW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 seedLoad,
    input  logic [DW-1:0]        seedIn,
    delta_sum_decoder_if.slave   bus,
    output logic                 satErr,
    input  logic                 satClr,
    output logic [CW-1:0]        cnt
);

    // Global advance enable: every stage moves together or holds together
    logic en;

    logic          s1_valid_q;
    logic [DW:0]   s1_delta_q;

    logic          s2_valid_q;
    logic [DW-1:0] s2_data_q;

    logic          s3_valid_q;
    logic [DW-1:0] s3_data_q;

    logic [DW-1:0] acc_q;
    logic [DW-1:0] acc_d;
    logic          sat_err_q;
    logic          sat_err_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    logic                 add;
    logic                 handoff;
    logic [DW-1:0]        base;
    logic signed [DW+1:0] sum;
    logic [DW-1:0]        result;
    logic                 saturated;

    assign en          = !s3_valid_q || bus.sReady;
    assign bus.dReady  = en;
    assign bus.sOut    = s3_data_q;
    assign bus.sValid  = s3_valid_q;
    assign satErr      = sat_err_q;
    assign cnt         = cnt_q;

    assign add     = en && s1_valid_q;
    assign handoff = s3_valid_q && bus.sReady;

    // Saturating add of the S1 delta onto the base (seed overrides acc)
    always_comb begin
        base      = seedLoad ? seedIn : acc_q;
        sum       = $signed({2'b00, base}) + $signed({s1_delta_q[DW], s1_delta_q});
        result    = sum[DW-1:0];
        saturated = 1'b0;
        // sum spans -(2^DW)..2*(2^DW-1): sign bit marks underflow, bit DW overflow
        if (sum[DW+1]) begin
            result    = '0;
            saturated = 1'b1;
        end else if (sum[DW]) begin
            result    = '1;
            saturated = 1'b1;
        end
    end

    // Next-state for accumulator, sticky saturation flag and hand-off counter
    always_comb begin
        acc_d     = acc_q;
        sat_err_d = sat_err_q;
        cnt_d     = cnt_q;

        if (add) begin
            acc_d = result;
        end else if (seedLoad) begin
            acc_d = seedIn;
        end

        if (add && saturated) begin
            sat_err_d = 1'b1;
        end else if (satClr) begin
            sat_err_d = 1'b0;
        end

        if (handoff) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // S1: capture the incoming delta when the pipeline advances
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_delta_q <= '0;
        end else if (en) begin
            s1_valid_q <= bus.dValid;
            s1_delta_q <= bus.dIn;
        end
    end

    // S2: hold the accumulated result of the S1 delta
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else if (en) begin
            s2_valid_q <= s1_valid_q;
            s2_data_q  <= result;
        end
    end

    // S3: output register, frozen while downstream back-pressures
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_valid_q <= 1'b0;
            s3_data_q  <= '0;
        end else if (en) begin
            s3_valid_q <= s2_valid_q;
            s3_data_q  <= s2_data_q;
        end
    end

    // Accumulator, saturation flag and emitted-sample counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            sat_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            acc_q     <= acc_d;
            sat_err_q <= sat_err_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_delta_sum_decoder.sv
// Directed testbench for delta_sum_decoder with hand-computed expectations.
module tb_delta_sum_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       seedLoad = 1'b0;
    logic [3:0] seedIn = 4'd0;
    logic       satErr;
    logic       satClr = 1'b0;
    logic [7:0] cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] cap_q[$];

    delta_sum_decoder_if #(.DW(4)) bus();

    delta_sum_decoder #(.DW(4), .CW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .seedLoad (seedLoad),
        .seedIn   (seedIn),
        .bus      (bus),
        .satErr   (satErr),
        .satClr   (satClr),
        .cnt      (cnt)
    );

    always #5 clk = ~clk;

    // Record every sample handed off downstream
    always @(posedge clk) begin
        if (bus.sValid && bus.sReady) cap_q.push_back(bus.sOut);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] d);
        check_eq("send_ready", int'(bus.dReady), 1);
        bus.dValid = 1'b1;
        bus.dIn    = d;
        step();
        bus.dValid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input int exp);
        int waited = 0;
        while (!bus.sValid && waited < 8) begin
            step();
            waited++;
        end
        check_eq({tag, "_valid"}, int'(bus.sValid), 1);
        if (bus.sValid) check_eq(tag, int'(bus.sOut), exp);
        step();
    endtask

    initial begin
        int sent;
        int stall_seen;

        bus.dIn    = '0;
        bus.dValid = 1'b0;
        bus.sReady = 1'b1;

        // Reset state
        step();
        step();
        rst = 1'b0;
        #1;
        check_eq("rst_svalid", int'(bus.sValid), 0);
        check_eq("rst_sout",   int'(bus.sOut),   0);
        check_eq("rst_cnt",    int'(cnt),        0);
        check_eq("rst_saterr", int'(satErr),     0);
        check_eq("rst_dready", int'(bus.dReady), 1);

        // Seed 5, deltas +3,-2,+1 back-to-back -> 8,6,7
        seedLoad = 1'b1; seedIn = 4'd5;
        step();
        seedLoad = 1'b0;
        bus.dValid = 1'b1; bus.dIn = 5'd3;
        step();
        check_eq("t1_lat1", int'(bus.sValid), 0);
        bus.dIn = 5'b11110;
        step();
        check_eq("t1_lat2", int'(bus.sValid), 0);
        bus.dIn = 5'd1;
        step();
        check_eq("t1_v0", int'(bus.sValid), 1);
        check_eq("t1_s0", int'(bus.sOut), 8);
        bus.dValid = 1'b0;
        step();
        check_eq("t1_s1", int'(bus.sOut), 6);
        step();
        check_eq("t1_s2", int'(bus.sOut), 7);
        step();
        check_eq("t1_idle",   int'(bus.sValid), 0);
        check_eq("t1_cnt",    int'(cnt),        3);
        check_eq("t1_saterr", int'(satErr),     0);

        // Saturation high/low, sticky flag, set-wins-over-clear
        seedLoad = 1'b1; seedIn = 4'd12;
        step();
        seedLoad = 1'b0;
        send(5'd10);
        expect_out("t2_sat_hi", 15);
        check_eq("t2_saterr_hi", int'(satErr), 1);
        send(5'b10001);
        expect_out("t2_minus15", 0);
        check_eq("t2_sticky", int'(satErr), 1);
        satClr = 1'b1;
        step();
        satClr = 1'b0;
        check_eq("t2_clr", int'(satErr), 0);
        send(5'b10000);
        satClr = 1'b1;
        step();
        satClr = 1'b0;
        check_eq("t2_set_wins", int'(satErr), 1);
        expect_out("t2_sat_lo", 0);
        satClr = 1'b1;
        step();
        satClr = 1'b0;
        check_eq("t2_clr2", int'(satErr), 0);

        // Seed 0, six +1 deltas, 4-cycle downstream stall
        seedLoad = 1'b1; seedIn = 4'd0;
        step();
        seedLoad = 1'b0;
        cap_q.delete();
        sent = 0;
        stall_seen = 0;
        for (int c = 0; c < 40 && cap_q.size() < 6; c++) begin
            bus.sReady = (c >= 3 && c <= 6) ? 1'b0 : 1'b1;
            bus.dValid = (sent < 6);
            bus.dIn    = 5'd1;
            #1;
            if (!bus.dReady) stall_seen = 1;
            if (bus.sValid) check_eq("t3_order", int'(bus.sOut), cap_q.size() + 1);
            if (bus.dValid && bus.dReady) sent++;
            @(posedge clk);
            #1;
        end
        bus.dValid = 1'b0;
        bus.sReady = 1'b1;
        check_eq("t3_sent",  sent, 6);
        check_eq("t3_stall", stall_seen, 1);
        check_eq("t3_count", cap_q.size(), 6);
        for (int i = 0; i < 6 && i < cap_q.size(); i++)
            check_eq("t3_seq", int'(cap_q[i]), i + 1);

        // Seed coincident with the S2 add: base becomes seedIn
        send(5'b11100);
        seedLoad = 1'b1; seedIn = 4'd9;
        step();
        seedLoad = 1'b0;
        expect_out("t4_seed_add", 5);
        send(5'd2);
        expect_out("t4_next", 7);

        // Reset with deltas in flight
        send(5'd15);
        expect_out("t5_pre", 15);
        check_eq("t5_pre_saterr", int'(satErr), 1);
        send(5'd3);
        send(5'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("t5_svalid", int'(bus.sValid), 0);
        check_eq("t5_sout",   int'(bus.sOut),   0);
        check_eq("t5_cnt",    int'(cnt),        0);
        check_eq("t5_saterr", int'(satErr),     0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("t5_quiet", int'(bus.sValid), 0);
        end
        send(5'd4);
        expect_out("t5_post", 4);

        // Counter wrap after 256 hand-offs, then one more
        rst = 1'b1;
        step();
        rst = 1'b0;
        cap_q.delete();
        bus.dValid = 1'b1;
        bus.dIn    = 5'd0;
        repeat (256) step();
        bus.dValid = 1'b0;
        repeat (3) step();
        check_eq("t6_xfers", cap_q.size(), 256);
        check_eq("t6_wrap",  int'(cnt), 0);
        check_eq("t6_idle",  int'(bus.sValid), 0);
        send(5'd0);
        expect_out("t6_257", 0);
        check_eq("t6_cnt1", int'(cnt), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
